// File: rtl/rf_pkg.sv
// Register file geometry shared by the regfile and its write-back scheduler.
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    localparam logic [AW-1:0] X0 = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the regfile write port among NREQ write-back requesters and keeps the
// busy scoreboard the issue stage uses for RAW/WAW hazard detection.
module rf_wb_scheduler
    import rf_pkg::NREG, rf_pkg::X0;
#(
    parameter int NREQ = 2,
    parameter int AW   = rf_pkg::AW,
    parameter int DW   = rf_pkg::DW
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic [AW-1:0]       chk_rs1,
    input  logic [AW-1:0]       chk_rs2,
    output logic                chk_busy,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_rd,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic                rf_wen,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic                err_unexpected
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            any_gnt;
    logic [AW-1:0]   g_rd;
    logic [DW-1:0]   g_data;
    logic            issue_fire;
    logic            wb_err;

    logic [AW-1:0] rd_arr   [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign rd_arr[g]   = req_rd[g*AW +: AW];
        assign data_arr[g] = req_data[g*DW +: DW];
    end

    rr_arbiter #(.N(NREQ), .IW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt   = |gnt;
    assign req_ready = gnt;
    assign g_rd      = rd_arr[gnt_idx];
    assign g_data    = data_arr[gnt_idx];

    // Registered busy only: a clear in flight is not forwarded, so WAW stalls.
    assign issue_ready = !issue_valid || issue_rd == X0 || !busy[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && issue_rd != X0;
    assign chk_busy    = busy[chk_rs1] | busy[chk_rs2];
    assign wb_err      = any_gnt && g_rd != X0 && !busy[g_rd];

    // Clear tracks the regfile commit edge, i.e. when the output register holds the write.
    always_comb begin
        busy_next = busy;
        if (rf_wen)
            busy_next[rf_waddr] = 1'b0;
        if (issue_fire)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: state uses non-blocking assignments so all flops sample pre-edge values together.
    // NOTE: the scoreboard is plain flops, not RAM, so it is reset like any other register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= '0;
            ptr            <= PW'(NREQ - 1);
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            busy <= busy_next;
            if (any_gnt) begin
                ptr      <= gnt_idx;
                rf_wen   <= (g_rd != X0);
                rf_waddr <= g_rd;
                rf_wdata <= g_data;
            end else begin
                rf_wen <= 1'b0;
            end
            if (wb_err)
                err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed vector table, hand-written corner sequences, then random traffic
// checked against a set-based scoreboard model.
module tb_rf_wb_scheduler;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clock;
    logic                reset_n;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [AW-1:0]       chk_rs1;
    logic [AW-1:0]       chk_rs2;
    logic                chk_busy;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_rd;
    logic [NREQ*DW-1:0]  req_data;
    logic                rf_wen;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                err_unexpected;

    rf_wb_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_ready    (issue_ready),
        .chk_rs1        (chk_rs1),
        .chk_rs2        (chk_rs2),
        .chk_busy       (chk_busy),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rd         (req_rd),
        .req_data       (req_data),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .err_unexpected (err_unexpected)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [1:0]  rv;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        e_iready;
        logic        e_chk;
        logic [1:0]  e_rr;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [1:0] rv,
        input logic [4:0] rd0, input logic [31:0] d0, input logic [4:0] rd1, input logic [31:0] d1,
        input logic e_iready, input logic e_chk, input logic [1:0] e_rr,
        input logic e_wen, input logic [4:0] e_waddr, input logic [31:0] e_wdata);
        vec_t v;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rv = rv;
        v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1;
        v.e_iready = e_iready; v.e_chk = e_chk; v.e_rr = e_rr;
        v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [4:0] ird, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [1:0] rv,
                         input logic [4:0] rd0, input logic [31:0] d0,
                         input logic [4:0] rd1, input logic [31:0] d1);
        issue_valid = iv;
        issue_rd    = ird;
        chk_rs1     = rs1;
        chk_rs2     = rs2;
        req_valid   = rv;
        req_rd      = {rd1, rd0};
        req_data    = {d1, d0};
    endtask

    // Reference model: set of pending registers, last winner, output register, sticky error.
    bit          mb [32];
    int          last;
    bit          o_wen;
    logic [4:0]  o_addr;
    logic [31:0] o_data;
    bit          m_err;

    bit          rq_v  [NREQ];
    logic [4:0]  rq_rd [NREQ];
    logic [31:0] rq_d  [NREQ];

    function automatic logic [4:0] pick_rd();
        int start;
        start = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++)
            if (((start + k) % 8) != 0 && mb[(start + k) % 8])
                return 5'((start + k) % 8);
        return 5'($urandom_range(0, 7));
    endfunction

    logic        iv_r;
    logic [4:0]  ird_r, rs1_r, rs2_r;
    bit          e_iready, e_chk;
    int          gidx;
    logic [4:0]  g_rd;

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        vecs[0]  = mk(1,  5,  5, 2'b00,  0, 32'h0,   0, 32'h0,        1, 0, 2'b00, 0,  0, 32'h0);
        vecs[1]  = mk(1,  7,  5, 2'b00,  0, 32'h0,   0, 32'h0,        1, 1, 2'b00, 0,  0, 32'h0);
        vecs[2]  = mk(1,  7,  5, 2'b10,  0, 32'h0,   5, 32'hDEADBEEF, 0, 1, 2'b10, 1,  5, 32'hDEADBEEF);
        vecs[3]  = mk(1,  7,  5, 2'b00,  0, 32'h0,   0, 32'h0,        0, 1, 2'b00, 0,  5, 32'hDEADBEEF);
        vecs[4]  = mk(1,  7,  5, 2'b01,  7, 32'h77,  0, 32'h0,        0, 0, 2'b01, 1,  7, 32'h77);
        vecs[5]  = mk(1,  7,  7, 2'b00,  0, 32'h0,   0, 32'h0,        0, 1, 2'b00, 0,  7, 32'h77);
        vecs[6]  = mk(1,  7,  7, 2'b00,  0, 32'h0,   0, 32'h0,        1, 0, 2'b00, 0,  7, 32'h77);
        vecs[7]  = mk(1, 10,  7, 2'b10,  0, 32'h0,   7, 32'h7007,     1, 1, 2'b10, 1,  7, 32'h7007);
        vecs[8]  = mk(1, 11, 10, 2'b00,  0, 32'h0,   0, 32'h0,        1, 1, 2'b00, 0,  7, 32'h7007);
        vecs[9]  = mk(1, 12,  0, 2'b11, 10, 32'hA0, 11, 32'hB1,       1, 0, 2'b01, 1, 10, 32'hA0);
        vecs[10] = mk(1, 13, 10, 2'b11, 12, 32'hC0, 11, 32'hB1,       1, 1, 2'b10, 1, 11, 32'hB1);
        vecs[11] = mk(1, 14, 11, 2'b11, 12, 32'hC0, 13, 32'hD1,       1, 1, 2'b01, 1, 12, 32'hC0);
        vecs[12] = mk(0,  0, 12, 2'b11, 14, 32'hE0, 13, 32'hD1,       1, 1, 2'b10, 1, 13, 32'hD1);
        vecs[13] = mk(0,  0, 13, 2'b01, 14, 32'hE0,  0, 32'h0,        1, 1, 2'b01, 1, 14, 32'hE0);
        vecs[14] = mk(0,  0, 14, 2'b00,  0, 32'h0,   0, 32'h0,        1, 1, 2'b00, 0, 14, 32'hE0);
        vecs[15] = mk(1, 20, 14, 2'b10,  0, 32'h0,   0, 32'h5555,     1, 0, 2'b10, 0,  0, 32'h5555);
        vecs[16] = mk(0,  0, 20, 2'b01,  0, 32'h1234, 0, 32'h0,       1, 1, 2'b01, 0,  0, 32'h1234);
        vecs[17] = mk(0,  0, 20, 2'b11,  0, 32'h1111, 0, 32'h2222,    1, 1, 2'b10, 0,  0, 32'h2222);
        vecs[18] = mk(0,  0, 20, 2'b01,  0, 32'h1111, 0, 32'h0,       1, 1, 2'b01, 0,  0, 32'h1111);

        repeat (2) @(posedge clock);
        #1;
        check("reset rf_wen", 32'(rf_wen), 32'h0);
        check("reset rf_waddr", 32'(rf_waddr), 32'h0);
        check("reset rf_wdata", rf_wdata, 32'h0);
        check("reset err", 32'(err_unexpected), 32'h0);
        check("reset chk_busy", 32'(chk_busy), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].iv, vecs[i].ird, vecs[i].rs1, 5'd0, vecs[i].rv,
                  vecs[i].rd0, vecs[i].d0, vecs[i].rd1, vecs[i].d1);
            #1;
            check($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_iready));
            check($sformatf("v%0d chk_busy", i), 32'(chk_busy), 32'(vecs[i].e_chk));
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
            @(posedge clock);
            #1;
            check($sformatf("v%0d rf_wen", i), 32'(rf_wen), 32'(vecs[i].e_wen));
            check($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
            check($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d err", i), 32'(err_unexpected), 32'h0);
        end

        // Write-back to a register that was never issued: sticky error.
        drive(0, 0, 0, 0, 2'b01, 9, 32'h99, 0, 0);
        #1;
        check("err req_ready", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1;
        check("err set", 32'(err_unexpected), 32'h1);
        check("err rf_wen", 32'(rf_wen), 32'h1);
        check("err rf_waddr", 32'(rf_waddr), 32'd9);
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("err sticky %0d", i), 32'(err_unexpected), 32'h1);
        end

        // Reset while busy bits are set and a write sits in the output register.
        drive(1, 3, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clock); #1;
        drive(1, 4, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clock); #1;
        drive(0, 0, 4, 3, 2'b10, 0, 0, 3, 32'h33);
        #1;
        check("rst pre req_ready", 32'(req_ready), 32'h2);
        check("rst pre chk_busy", 32'(chk_busy), 32'h1);
        @(posedge clock); #1;
        check("rst pre rf_wen", 32'(rf_wen), 32'h1);
        drive(1, 4, 4, 20, 2'b00, 0, 0, 0, 0);
        #1;
        check("rst pre issue_ready", 32'(issue_ready), 32'h0);
        reset_n = 1'b0;
        #1;
        check("rst rf_wen", 32'(rf_wen), 32'h0);
        check("rst rf_waddr", 32'(rf_waddr), 32'h0);
        check("rst rf_wdata", rf_wdata, 32'h0);
        check("rst err", 32'(err_unexpected), 32'h0);
        check("rst chk_busy", 32'(chk_busy), 32'h0);
        check("rst issue_ready", 32'(issue_ready), 32'h1);
        @(negedge clock);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 2'b11, 0, 32'hAAAA, 0, 32'hBBBB);
        #1;
        check("post-rst tie", 32'(req_ready), 32'h1);
        @(posedge clock); #1;
        check("post-rst rf_wen", 32'(rf_wen), 32'h0);
        check("post-rst rf_wdata", rf_wdata, 32'hAAAA);

        // Random traffic against the model, starting from the state just reached.
        for (int r = 0; r < 32; r++) mb[r] = 0;
        last   = 0;
        o_wen  = 0;
        o_addr = 5'd0;
        o_data = 32'hAAAA;
        m_err  = 0;
        for (int i = 0; i < NREQ; i++) rq_v[i] = 0;

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq_v[i] && $urandom_range(0, 1) == 1) begin
                    rq_v[i]  = 1;
                    rq_rd[i] = ($urandom_range(0, 3) != 0) ? pick_rd() : 5'($urandom_range(0, 7));
                    rq_d[i]  = $urandom;
                end
            end
            iv_r  = 1'($urandom_range(0, 1));
            ird_r = 5'($urandom_range(0, 7));
            rs1_r = 5'($urandom_range(0, 8));
            rs2_r = 5'($urandom_range(0, 8));
            drive(iv_r, ird_r, rs1_r, rs2_r, {rq_v[1], rq_v[0]},
                  rq_rd[0], rq_d[0], rq_rd[1], rq_d[1]);
            #1;

            e_iready = !iv_r || ird_r == 0 || !mb[ird_r];
            e_chk    = mb[rs1_r] || mb[rs2_r];
            gidx     = -1;
            for (int k = 1; k <= NREQ; k++)
                if (gidx < 0 && rq_v[(last + k) % NREQ]) gidx = (last + k) % NREQ;
            check($sformatf("rnd%0d issue_ready", c), 32'(issue_ready), 32'(e_iready));
            check($sformatf("rnd%0d chk_busy", c), 32'(chk_busy), 32'(e_chk));
            check($sformatf("rnd%0d req_ready", c), 32'(req_ready),
                  (gidx >= 0) ? (32'h1 << gidx) : 32'h0);

            g_rd = (gidx >= 0) ? rq_rd[gidx] : 5'd0;
            if (gidx >= 0 && g_rd != 0 && !mb[g_rd]) m_err = 1;
            if (o_wen) mb[o_addr] = 0;
            if (iv_r && e_iready && ird_r != 0) mb[ird_r] = 1;
            if (gidx >= 0) begin
                last   = gidx;
                o_wen  = (g_rd != 0);
                o_addr = g_rd;
                o_data = rq_d[gidx];
                rq_v[gidx] = 0;
            end else begin
                o_wen = 0;
            end

            @(posedge clock);
            #1;
            check($sformatf("rnd%0d rf_wen", c), 32'(rf_wen), 32'(o_wen));
            check($sformatf("rnd%0d rf_waddr", c), 32'(rf_waddr), 32'(o_addr));
            check($sformatf("rnd%0d rf_wdata", c), rf_wdata, o_data);
            check($sformatf("rnd%0d err", c), 32'(err_unexpected), 32'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
